mux2a1_cond_l2: RTL

Layer-2 2:1 lane multiplexer: the transmit-side counterpart of the layer-2 1:2 demux. It takes two 8-bit lanes, each carrying every other word of the original stream, and re-serialises them into one stream in the `clk_4f` domain. Lane 0 always carries the first word after reset. Each lane has a small FIFO to absorb skew, and a strict-alternation selector restores the original word order. Its output feeds the layer-1 mux stage.

---
 rtl/mux2a1_cond_l2.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux2a1_cond_l2.sv
// Layer-2 2:1 lane multiplexer: two skew-absorbing lane FIFOs drained by a
// strict-alternation selector that restores the original word order.
module mux2a1_cond_l2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_4f,
  input  logic                  reset_L,
  input  logic                  valid_in0,
  input  logic [DATA_WIDTH-1:0] data_in0_muxL2,
  input  logic                  valid_in1,
  input  logic [DATA_WIDTH-1:0] data_in1_muxL2,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out_muxL2,
  output logic                  fifo_full0,
  output logic                  fifo_full1,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    SEL_LANE0 = 1'b0,
    SEL_LANE1 = 1'b1
  } sel_e;

  sel_e                  sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;

  logic [1:0]            lane_valid;
  logic [1:0]            lane_push;
  logic [1:0]            lane_pop;
  logic [1:0]            lane_full;
  logic [DATA_WIDTH-1:0] lane_data [2];
  logic [DATA_WIDTH-1:0] lane_head [2];

  assign lane_valid   = {valid_in1, valid_in0};
  assign lane_data[0] = data_in0_muxL2;
  assign lane_data[1] = data_in1_muxL2;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam sel_e OWNER = (g == 0) ? SEL_LANE0 : SEL_LANE1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  full, pop, push;

    assign full = (cnt_q == CW'(DEPTH));
    // Pop decision sees only the registered count, so a word written this
    // edge cannot be read out on the same edge.
    assign pop  = (sel_q == OWNER) && (cnt_q != '0);
    // A full lane still accepts when its head leaves on the same edge.
    assign push = lane_valid[g] && (!full || pop);

    assign lane_full[g] = full;
    assign lane_pop[g]  = pop;
    assign lane_push[g] = push;
    assign lane_head[g] = mem_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk_4f) begin
      if (push) mem_q[wr_ptr_q] <= lane_data[g];
    end
  end

  always_comb begin
    sel_d   = sel_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ovf_d   = ovf_q | (|(lane_valid & ~lane_push));
    if (lane_pop[0]) begin
      valid_d = 1'b1;
      data_d  = lane_head[0];
      sel_d   = SEL_LANE1;
    end else if (lane_pop[1]) begin
      valid_d = 1'b1;
      data_d  = lane_head[1];
      sel_d   = SEL_LANE0;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      sel_q   <= SEL_LANE0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_out      = valid_q;
  assign data_out_muxL2 = data_q;
  assign fifo_full0     = lane_full[0];
  assign fifo_full1     = lane_full[1];
  assign overflow       = ovf_q;

endmodule
